// File: rtl/mem_access_unit_if.sv
// Bundled request/response and data-memory signals for mem_access_unit.
// The slave side is the unit. The master side is the pipeline plus the memory.
interface mem_access_unit_if #(
    parameter int ADDR_W = 10
) ();

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;

    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_dataIn;
    logic              mem_memWrite;
    logic              mem_memRead;
    logic [31:0]       mem_dataOut;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_dataOut,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_dataIn, mem_memWrite, mem_memRead
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_dataOut,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_dataIn, mem_memWrite, mem_memRead
    );

endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between EX/MEM and a word-wide, big-endian data memory.
// Sub-word stores are done as read-modify-write. Misaligned and out-of-range accesses fault.
module mem_access_unit #(
    parameter int ADDR_W      = 10,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_RMW_READ  = 3'd3;
    localparam logic [2:0] S_RMW_WRITE = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    logic [2:0]        r_state;
    logic [2:0]        r_op;
    logic [1:0]        r_off;
    logic [15:0]       r_wdata;
    logic              r_resp_valid;
    logic              r_resp_fault;
    logic [31:0]       r_resp_rdata;
    logic              r_mem_we;
    logic              r_mem_re;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_din;

    logic              w_accept;
    logic              w_is_load;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_fault;

    // Byte offset 0 is the most significant lane. The expression ~off equals 3-off for a 2-bit offset.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  op,
                                                 input logic [1:0]  off);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        // NOTE: blocking assignments here are intentional; function locals are combinational temporaries.
        lane_b = word[{~off, 3'b000} +: 8];
        lane_h = off[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LW:   result = word;
            OP_LH:   result = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  result = {16'd0, lane_h};
            OP_LB:   result = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  result = {24'd0, lane_b};
            default: result = 32'd0;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [2:0]  op,
                                                input logic [1:0]  off,
                                                input logic [15:0] wdata);
        logic [31:0] result;
        result = word;
        if (op == OP_SH) begin
            if (off[1]) result[15:0]  = wdata;
            else        result[31:16] = wdata;
        end else begin
            result[{~off, 3'b000} +: 8] = wdata[7:0];
        end
        return result;
    endfunction

    // Fault and access-class decode uses the live request, because it is resolved in the acceptance cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no latch is inferred.
        w_misaligned = 1'b0;
        case (bus.req_op)
            OP_LW, OP_SW:         w_misaligned = |bus.req_addr[1:0];
            OP_LH, OP_LHU, OP_SH: w_misaligned = bus.req_addr[0];
            default:              w_misaligned = 1'b0;
        endcase
    end

    assign w_out_of_range = CHECK_RANGE && ((bus.req_addr >> ADDR_W) != 32'd0);
    assign w_fault        = w_misaligned || w_out_of_range;
    assign w_is_load      = (bus.req_op <= OP_LBU);
    assign w_accept       = bus.req_valid && (r_state == S_IDLE);

    // Ready is gated by rst_n directly, so it is low while reset is asserted.
    assign bus.req_ready    = (r_state == S_IDLE) && rst_n;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_fault   = r_resp_fault;
    assign bus.resp_rdata   = r_resp_rdata;
    assign bus.mem_address  = r_mem_addr;
    assign bus.mem_dataIn   = r_mem_din;
    assign bus.mem_memWrite = r_mem_we;
    assign bus.mem_memRead  = r_mem_re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= OP_LW;
            r_off        <= 2'd0;
            r_wdata      <= 16'd0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the strobes default low each cycle.
            r_resp_valid <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.req_op;
                        r_off   <= bus.req_addr[1:0];
                        r_wdata <= bus.req_wdata[15:0];
                        if (w_fault) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else begin
                            r_mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            if (w_is_load) begin
                                r_state  <= S_READ;
                                r_mem_re <= 1'b1;
                            end else if (bus.req_op == OP_SW) begin
                                r_state   <= S_WRITE;
                                r_mem_we  <= 1'b1;
                                r_mem_din <= bus.req_wdata;
                            end else begin
                                r_state  <= S_RMW_READ;
                                r_mem_re <= 1'b1;
                            end
                        end
                    end
                end

                S_READ: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_fault <= 1'b0;
                    r_resp_rdata <= extract_load(bus.mem_dataOut, r_op, r_off);
                end

                S_WRITE, S_RMW_WRITE: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_fault <= 1'b0;
                    r_resp_rdata <= 32'd0;
                end

                S_RMW_READ: begin
                    r_state   <= S_RMW_WRITE;
                    r_mem_we  <= 1'b1;
                    r_mem_din <= merge_store(bus.mem_dataOut, r_op, r_off, r_wdata);
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_mem_we && r_mem_re));

    a_resp_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        r_resp_valid |=> !r_resp_valid);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-array reference model.
// It also runs the directed reset, store/load, sub-word and fault scenarios.
module tb_mem_access_unit;

    localparam int ADDR_W = 10;
    localparam int NBYTES = 1 << ADDR_W;
    localparam int NWORDS = NBYTES / 4;

    logic clk;
    logic rst_n;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W), .CHECK_RANGE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory seen by the DUT. The only process that writes it is the one below.
    logic [31:0] dut_mem [NWORDS];
    logic        pl_en;
    int          pl_idx;
    logic [31:0] pl_word;

    // Reference model: a flat big-endian byte array.
    logic [7:0]  ref_mem [NBYTES];

    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;
    logic [31:0] wr_addr, wr_data, rd_addr;

    int n_checks = 0;
    int n_pass   = 0;

    assign bus.mem_dataOut = dut_mem[bus.mem_address[ADDR_W-1:2]];

    always @(posedge clk) begin
        if (pl_en) dut_mem[pl_idx] <= pl_word;
        if (bus.mem_memWrite) begin
            dut_mem[bus.mem_address[ADDR_W-1:2]] <= bus.mem_dataIn;
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= 32'(bus.mem_address);
            wr_data <= bus.mem_dataIn;
        end
        if (bus.mem_memRead) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= 32'(bus.mem_address);
        end
        if (bus.mem_memRead && bus.mem_memWrite) both_cnt <= both_cnt + 1;
        if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd5:       return 4;
            3'd1, 3'd2, 3'd6: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int waddr);
        return {ref_mem[waddr], ref_mem[waddr+1], ref_mem[waddr+2], ref_mem[waddr+3]};
    endfunction

    task automatic preload(input int byte_addr, input logic [31:0] word);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = byte_addr / 4;
        pl_word = word;
        for (int i = 0; i < 4; i++) ref_mem[(byte_addr & ~3) + i] = word[8*(3-i) +: 8];
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request starting at a negedge and checks it against the model.
    task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int          size, lat, rd0, wr0, rs0, exp_lat, exp_rd, exp_wr;
        bit          got, exp_fault, is_load;
        logic [31:0] val, exp_rdata, exp_wdata;

        size      = op_size(op);
        is_load   = (op <= 3'd4);
        exp_fault = (addr >= 32'(NBYTES)) || ((addr % 32'(size)) != 0);
        exp_rdata = 32'd0;
        exp_wdata = 32'd0;
        if (!exp_fault) begin
            if (is_load) begin
                val = 32'd0;
                for (int i = 0; i < size; i++) val = (val << 8) | 32'(ref_mem[addr + 32'(i)]);
                if (op == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
                if (op == 3'd3 && val[7])  val = val | 32'hFFFF_FF00;
                exp_rdata = val;
            end else begin
                for (int i = 0; i < size; i++)
                    ref_mem[addr + 32'(i)] = wdata[8*(size-1-i) +: 8];
                exp_wdata = ref_word(int'(addr & ~32'd3));
            end
        end
        exp_lat = exp_fault ? 1 : (op == 3'd6 || op == 3'd7) ? 3 : 2;
        exp_rd  = (exp_fault || op == 3'd5) ? 0 : 1;
        exp_wr  = (exp_fault || is_load) ? 0 : 1;

        rd0 = rd_cnt; wr0 = wr_cnt; rs0 = resp_cnt;
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;

        lat = 1;
        got = 1'b0;
        while (!got && lat <= 8) begin
            if (bus.resp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, ".resp_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
            check({tag, ".fault"},   32'(bus.resp_fault), 32'(exp_fault));
            check({tag, ".rdata"},   bus.resp_rdata, exp_rdata);
            check({tag, ".n_read"},  32'(rd_cnt - rd0), 32'(exp_rd));
            check({tag, ".n_write"}, 32'(wr_cnt - wr0), 32'(exp_wr));
            if (exp_rd == 1) check({tag, ".rd_addr"}, rd_addr, addr & ~32'd3);
            if (exp_wr == 1) begin
                check({tag, ".wr_addr"}, wr_addr, addr & ~32'd3);
                check({tag, ".wr_data"}, wr_data, exp_wdata);
            end
            @(negedge clk);
            check({tag, ".pulse_one"}, 32'(resp_cnt - rs0), 32'd1);
            check({tag, ".ready_back"}, 32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, rs0, mism;
        logic [2:0]  op;
        logic [31:0] addr;
        int          r;

        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        pl_en         = 1'b0;
        pl_idx        = 0;
        pl_word       = 32'd0;
        rst_n         = 1'b1;
        #2 rst_n      = 1'b0;

        for (int i = 0; i < NWORDS; i++) preload(i * 4, $urandom);

        @(negedge clk);
        check("rst.ready",      32'(bus.req_ready), 32'd0);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.resp_fault", 32'(bus.resp_fault), 32'd0);
        check("rst.resp_rdata", bus.resp_rdata, 32'd0);
        check("rst.memWrite",   32'(bus.mem_memWrite), 32'd0);
        check("rst.memRead",    32'(bus.mem_memRead), 32'd0);
        check("rst.mem_addr",   32'(bus.mem_address), 32'd0);
        check("rst.mem_dataIn", bus.mem_dataIn, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.ready_after", 32'(bus.req_ready), 32'd1);

        do_req("sw10", 3'd5, 32'h10, 32'hDEADBEEF);
        do_req("lw10", 3'd0, 32'h10, 32'h0);
        check("lw10.value", bus.resp_rdata, 32'hDEADBEEF);

        preload(32'h20, 32'h11223344);
        do_req("sb22", 3'd7, 32'h22, 32'h000000AA);
        check("sb22.word", wr_data, 32'h1122AA44);

        preload(32'h30, 32'h80FF7F01);
        do_req("lb30",  3'd3, 32'h30, 32'h0);
        do_req("lbu31", 3'd4, 32'h31, 32'h0);
        do_req("lh32",  3'd1, 32'h32, 32'h0);
        do_req("lhu30", 3'd2, 32'h30, 32'h0);

        do_req("lw13",  3'd0, 32'h13,  32'h0);
        do_req("sh21",  3'd6, 32'h21,  32'h1234);
        do_req("lb400", 3'd3, 32'h400, 32'h0);

        // Reset during the read phase of a read-modify-write.
        preload(32'h24, 32'hCAFEF00D);
        rd0 = rd_cnt; wr0 = wr_cnt; rs0 = resp_cnt;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd7;
        bus.req_addr  = 32'h25;
        bus.req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort.read_phase", 32'(bus.mem_memRead), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort.read_drop",  32'(bus.mem_memRead), 32'd0);
        check("abort.write_low",  32'(bus.mem_memWrite), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort.no_write", 32'(wr_cnt - wr0), 32'd0);
        check("abort.no_resp",  32'(resp_cnt - rs0), 32'd0);
        check("abort.mem_word", dut_mem[32'h24 / 4], 32'hCAFEF00D);
        check("abort.ready",    32'(bus.req_ready), 32'd1);

        for (int t = 0; t < 250; t++) begin
            op = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r == 0) addr = $urandom;
            else        addr = 32'($urandom_range(0, NBYTES - 1));
            if (r >= 1 && r <= 6) addr = addr & ~32'(op_size(op) - 1);
            do_req("rand", op, addr, $urandom);
        end

        mism = 0;
        for (int i = 0; i < NWORDS; i++)
            if (dut_mem[i] !== ref_word(i * 4)) mism++;
        check("final.mem_mismatch_words", 32'(mism), 32'd0);
        check("final.rw_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer between the EX/MEM pipeline register and the word-wide, big-endian, byte-addressed data memory. It accepts one load/store request and drives the memory's address, dataIn, memWrite and memRead. It captures the memory's dataOut and returns an extracted, extended load result. Sub-word stores are done as read-modify-write, because the memory only writes whole words; misaligned and out-of-range accesses are faulted.

Parameters:
ADDR_W, 10, memory byte-address width; the word address is {addr[ADDR_W-1:2],2'b00}
CHECK_RANGE, 1, when 1, any set bit in req_addr[31:ADDR_W] faults the access

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE with rst_n high
req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
req_addr  in  32  byte address
req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0]
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and faults
resp_fault  out  1  valid with resp_valid; misaligned or out-of-range access
mem_address  out  ADDR_W  to memory address, always word-aligned
mem_dataIn  out  32  to memory dataIn
mem_memWrite  out  1  to memory memWrite
mem_memRead  out  1  to memory memRead
mem_dataOut  in  32  from memory dataOut

Behaviour:
- Reset is asynchronous and active-low: state=IDLE; resp_valid, resp_fault, resp_rdata, mem_memWrite, mem_memRead, mem_address and mem_dataIn all 0. Reset mid-operation aborts the access immediately and produces no response.
- Memory is level-sensitive, so all mem_* outputs are registers.
  - mem_memWrite is high only in WRITE and RMW_WRITE.
  - mem_memRead is high only in READ and RMW_READ.
  - The two are never high together.
  - mem_address and mem_dataIn are stable for the whole cycle in which mem_memWrite is high, and hold their value in other states.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - op, addr and wdata are latched on acceptance; later changes are ignored.
  - There is no response backpressure.
- Fault check at acceptance:
  - LW/SW with addr[1:0]!=0 faults.
  - LH/LHU/SH with addr[0]!=0 faults.
  - With CHECK_RANGE=1, addr[31:ADDR_W]!=0 faults.
  - On a fault the unit goes IDLE->RESP with resp_fault=1 and resp_rdata=0, and issues no memory access.
- States and transitions (N = acceptance cycle):
  - IDLE: accept. Fault -> RESP. Load -> READ. SW -> WRITE. SH/SB -> RMW_READ.
  - READ (N+1): memRead=1. At the edge, capture mem_dataOut -> RESP.
  - WRITE (N+1): memWrite=1, mem_dataIn=wdata -> RESP.
  - RMW_READ (N+1): memRead=1. At the edge, capture the word -> RMW_WRITE.
  - RMW_WRITE (N+2): memWrite=1, mem_dataIn=captured word with the selected lane replaced -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Latency from acceptance: fault 1 cycle; LW/LH/LHU/LB/LBU and SW 2 cycles; SH/SB 3 cycles. req_ready returns in the cycle after RESP.
- Lane mapping is big-endian:
  - Byte offset 0 is bits [31:24], offset 3 is bits [7:0].
  - Halfword offset 0 is bits [31:16], offset 2 is bits [15:0].
- Load extension: LH and LB sign-extend to 32 bits; LHU and LBU zero-extend; LW returns the word unchanged.
- Stores return resp_rdata=0 and resp_fault=0.

Test Plan:
- Reset: hold rst_n=0 -> req_ready=0, all outputs 0. Release -> req_ready=1 on the next cycle.
- SW 0xDEADBEEF to addr 0x10, then LW from 0x10 -> memWrite high exactly 1 cycle with mem_address=0x010; the LW's resp_rdata=0xDEADBEEF, 2 cycles after acceptance.
- Memory word 0x11223344 at 0x20, SB 0xAA to addr 0x22 -> memRead 1 cycle, then memWrite 1 cycle with mem_dataIn=0x1122AA44; resp_valid 3 cycles after acceptance.
- Memory word 0x80FF7F01 at 0x30:
  - LB 0x30 -> 0xFFFFFF80
  - LBU 0x31 -> 0x000000FF
  - LH 0x32 -> 0x00007F01
  - LHU 0x30 -> 0x000080FF
- LW at 0x13, SH at 0x21, and LB at 0x400 with CHECK_RANGE=1 -> each gives resp_fault=1 and resp_rdata=0 one cycle after acceptance, with memRead and memWrite never asserted.
- Assert rst_n=0 during RMW_READ of an SB -> memRead drops immediately, memWrite is never asserted, resp_valid never pulses, and memory is unchanged.
